// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide, one bit per cycle: result_valid VALUE_W+1 edges after accept (1 edge for divide-by-zero).
// Single op in flight; result holds until result_ready; flush/reset drop all work. MULDIV_SIGNED_EN enables signed ops.
module muldiv_unit #(
    parameter int VALUE_W    = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [2:0]            op,
    input  logic [VALUE_W-1:0]    src1,
    input  logic [VALUE_W-1:0]    src2,
    input  logic [REG_ADDR_W-1:0] start_rd,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [VALUE_W-1:0]    result,
    output logic [REG_ADDR_W-1:0] result_rd
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       counter;
    // Multiply: {product_hi, product_lo}. Divide: {remainder, quotient}.
    logic [2*VALUE_W-1:0]   acc;
    logic [VALUE_W-1:0]     operand;
    logic [2:0]             op_q;
    logic                   neg_a;
    logic                   neg_b;

    logic                   s1_signed, s2_signed, a_neg_in, b_neg_in;
    logic [VALUE_W-1:0]     mag1, mag2;
    logic [VALUE_W:0]       mul_sum, div_shift, div_trial;
    logic [2*VALUE_W-1:0]   mul_next, div_next, prod_fix;
    logic [VALUE_W-1:0]     quo_fix, rem_fix;

    always_comb begin
        s1_signed = 1'b0;
        s2_signed = 1'b0;
`ifdef MULDIV_SIGNED_EN
        s1_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        s2_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
`endif
        a_neg_in = s1_signed & src1[VALUE_W-1];
        b_neg_in = s2_signed & src2[VALUE_W-1];
        mag1     = a_neg_in ? -src1 : src1;
        mag2     = b_neg_in ? -src2 : src2;
    end

    always_comb begin
        mul_sum   = {1'b0, acc[2*VALUE_W-1:VALUE_W]} + (acc[0] ? {1'b0, operand} : '0);
        mul_next  = {mul_sum, acc[VALUE_W-1:1]};
        div_shift = {acc[2*VALUE_W-1:VALUE_W], acc[VALUE_W-1]};
        div_trial = div_shift - {1'b0, operand};
        // Top bit set means the trial subtraction went negative: restore.
        if (div_trial[VALUE_W])
            div_next = {div_shift[VALUE_W-1:0], acc[VALUE_W-2:0], 1'b0};
        else
            div_next = {div_trial[VALUE_W-1:0], acc[VALUE_W-2:0], 1'b1};
    end

    always_comb begin
        prod_fix = (neg_a ^ neg_b) ? -acc : acc;
        quo_fix  = (neg_a ^ neg_b) ? -acc[VALUE_W-1:0] : acc[VALUE_W-1:0];
        rem_fix  = neg_a ? -acc[2*VALUE_W-1:VALUE_W] : acc[2*VALUE_W-1:VALUE_W];
        result   = '0;
        if (result_valid) begin
            case (op_q)
                3'b000:                 result = prod_fix[VALUE_W-1:0];
                3'b001, 3'b010, 3'b011: result = prod_fix[2*VALUE_W-1:VALUE_W];
                3'b100, 3'b101:         result = quo_fix;
                default:                result = rem_fix;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            counter      <= '0;
            acc          <= '0;
            operand      <= '0;
            op_q         <= '0;
            neg_a        <= 1'b0;
            neg_b        <= 1'b0;
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            result_rd    <= '0;
        end else if (flush) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        op_q        <= op;
                        result_rd   <= start_rd;
                        counter     <= '0;
                        start_ready <= 1'b0;
                        if (op[2] && (src2 == '0)) begin
                            // Divide by zero: quotient all ones, remainder is the raw dividend.
                            acc          <= {src1, {VALUE_W{1'b1}}};
                            neg_a        <= 1'b0;
                            neg_b        <= 1'b0;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            acc     <= {{VALUE_W{1'b0}}, (op[2] ? mag1 : mag2)};
                            operand <= op[2] ? mag2 : mag1;
                            neg_a   <= a_neg_in;
                            neg_b   <= b_neg_in;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc     <= op_q[2] ? div_next : mul_next;
                    counter <= counter + CNT_W'(1);
                    if (counter == CNT_W'(VALUE_W - 1)) begin
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized scoreboard bench for muldiv_unit against a 64-bit arithmetic reference model.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [2:0]  op = '0;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic [4:0]  start_rd = '0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic [4:0]  result_rd;

    muldiv_unit dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .src1(src1), .src2(src2), .start_rd(start_rd),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .result_rd(result_rd)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 2;  // 0 random, 1 held low, 2 held high

    always @(posedge clock) cyc <= cyc + 1;

    always begin
        @(posedge clock);
        #2;
        case (ready_mode)
            0:       result_ready = ($urandom_range(0, 3) != 0);
            1:       result_ready = 1'b0;
            default: result_ready = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ua, ub, p;
        bit sgn;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = 1'b1;
`endif
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = sgn ? {{32{a[31]}}, a} : ua;
        sb = sgn ? {{32{b[31]}}, b} : ub;
        case (f)
            3'd0:    p = ua * ub;
            3'd1:    p = (sa * sb) >>> 32;
            3'd2:    p = (sa * ub) >>> 32;
            3'd3:    p = (ua * ub) >>> 32;
            3'd4:    p = (b == 0) ? 64'hFFFF_FFFF : sa / sb;
            3'd5:    p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
            3'd6:    p = (b == 0) ? ua : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    // Monitor: pops one expectation per result_valid episode, then checks stability while stalled.
    bit   seen = 0;
    bit   bogus = 0;
    exp_t cur;
    always @(negedge clock) begin
        if (reset_n) begin
            if (!result_valid) begin
                seen  = 0;
                bogus = 0;
            end else if (!seen) begin
                seen = 1;
                if (q.size() == 0) begin
                    bogus = 1;
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=valid(res=%h rd=%0d) expected=no result", result, result_rd);
                end else begin
                    cur = q.pop_front();
                    chk("result", result, cur.res);
                    chk("result_rd", 32'(result_rd), 32'(cur.rd));
                    chk("latency", 32'(cyc - cur.acc_cyc + 1), 32'(cur.lat));
                end
            end else if (!bogus) begin
                chk("result_stable", result, cur.res);
                chk("result_rd_stable", 32'(result_rd), 32'(cur.rd));
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push);
        int n = 0;
        exp_t e;
        @(negedge clock);
        while (!start_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!start_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=start_ready low expected=high within 300 cycles");
            return;
        end
        op = f; src1 = a; src2 = b; start_rd = rd; start_valid = 1'b1;
        @(posedge clock);
        #1;
        start_valid = 1'b0;
        op = 3'($urandom); src1 = $urandom; src2 = $urandom; start_rd = 5'($urandom);
        if (push) begin
            e.res = ref_model(f, a, b);
            e.rd = rd;
            e.acc_cyc = cyc;
            e.lat = (f[2] && b == 0) ? 1 : 33;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || result_valid || !start_ready) && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=pending=%0d expected=0", q.size());
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f;
        int n;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_start_ready", 32'(start_ready), 32'd1);
        chk("reset_result_valid", 32'(result_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_result_rd", 32'(result_rd), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases; expectations come from the reference model.
        issue(3'd0, 32'd7, 32'd6, 5'd3, 1);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1);
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1);
        issue(3'd5, 32'd100, 32'd7, 5'd4, 1);
        issue(3'd7, 32'd100, 32'd7, 5'd5, 1);
        issue(3'd5, 32'd5, 32'd0, 5'd6, 1);
        issue(3'd7, 32'd5, 32'd0, 5'd7, 1);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1);
        issue(3'd4, -32'sd7, 32'd2, 5'd10, 1);
        issue(3'd6, -32'sd7, 32'd2, 5'd11, 1);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1);
        issue(3'd2, 32'hFFFF_FFFE, 32'h8000_0003, 5'd14, 1);
        issue(3'd6, -32'sd5, 32'd0, 5'd15, 1);
        issue(3'd0, 32'd12345, 32'd678, 5'd0, 1);
        wait_idle();

        // Stall in DONE: outputs stable, new requests ignored.
        ready_mode = 1;
        issue(3'd0, 32'd3, 32'd5, 5'd2, 1);
        n = 0;
        while (!result_valid && n < 60) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            start_valid = 1'b1; op = 3'd5; src1 = $urandom; src2 = 32'd0;
            chk("hold_start_ready", 32'(start_ready), 32'd0);
            chk("hold_result_valid", 32'(result_valid), 32'd1);
        end
        @(negedge clock);
        start_valid = 1'b0;
        ready_mode = 2;
        result_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("release_result_valid", 32'(result_valid), 32'd0);
        chk("release_start_ready", 32'(start_ready), 32'd1);
        wait_idle();

        // Flush during BUSY cycle 10: no result ever appears.
        issue(3'd5, 32'd999, 32'd3, 5'd9, 0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("flush_start_ready", 32'(start_ready), 32'd1);
        chk("flush_result_valid", 32'(result_valid), 32'd0);
        repeat (40) @(negedge clock);

        // Flush wins over a simultaneous request.
        @(negedge clock);
        flush = 1'b1; start_valid = 1'b1; op = 3'd5; src1 = 32'd1; src2 = 32'd0;
        @(posedge clock);
        #1;
        flush = 1'b0; start_valid = 1'b0;
        chk("flush_start_not_accepted", 32'(start_ready), 32'd1);
        repeat (5) @(negedge clock);

        // Asynchronous reset mid-BUSY.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 0);
        repeat (5) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_result_valid", 32'(result_valid), 32'd0);
        chk("midreset_start_ready", 32'(start_ready), 32'd1);
        chk("midreset_result", result, 32'd0);
        chk("midreset_result_rd", 32'(result_rd), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);

        // Randomized traffic with random writeback backpressure.
        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            issue(f, a, b, 5'($urandom), 1);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M-style multiply/divide execution unit, directly downstream of the register file.
- Consumes the two register read values (read1, read2) plus the destination register index.
- Computes over several cycles, then presents the result and rd for writeback into the register file's writeData/rd/RegWrite path.
- Valid/ready handshakes on both sides. A flush input kills in-flight work.

Parameters:
- VALUE_W, 32, operand and result width in bits.
- REG_ADDR_W, 5, destination register index width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > VALUE_W.

Ports:
- clock  input  1  single clock; all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of any operation in progress.
- start_valid  input  1  request present on op/src1/src2/start_rd.
- start_ready  output  1  unit can accept a request (IDLE only).
- op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- src1  input  VALUE_W  rs1 value (multiplicand / dividend).
- src2  input  VALUE_W  rs2 value (multiplier / divisor).
- start_rd  input  REG_ADDR_W  destination register index.
- result_valid  output  1  result and result_rd valid.
- result_ready  input  1  writeback consumes the result.
- result  output  VALUE_W  computed value.
- result_rd  output  REG_ADDR_W  destination carried from start_rd.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async, reset_n low):
  - state=IDLE, counter=0, result=0, result_rd=0, result_valid=0, start_ready=1.
  - Reset mid-operation discards all state immediately; no stale result after release.
- IDLE:
  - start_ready=1.
  - Accept when start_valid & ~flush at a rising edge; latch op, operands, start_rd.
  - Divisor==0 on a divide/rem op: go directly to DONE.
  - Otherwise go to BUSY with counter=0.
- BUSY:
  - One bit per cycle: shift-add multiply (2*VALUE_W product register), restoring divide (quotient/remainder registers).
  - Leave BUSY after counter reaches VALUE_W-1, i.e. exactly VALUE_W BUSY cycles, then DONE.
  - Latency: result_valid rises VALUE_W+1 edges after the accepting edge (33 for default).
  - Divide-by-zero latency: 1 edge.
- DONE:
  - result_valid=1; result and result_rd stable until consumed.
  - result_ready high at an edge: return to IDLE, result_valid drops.
  - No new request accepted in the same edge; throughput is one op per VALUE_W+2 cycles minimum.
- Result selection:
  - MUL = product[VALUE_W-1:0]; MULH* = product[2*VALUE_W-1:VALUE_W].
  - DIV* = quotient; REM* = remainder.
- Divide by zero: quotient = all ones; remainder = src1 (unmodified, also for signed ops).
- flush:
  - In any state: next state IDLE, result_valid=0, in-flight or unconsumed result dropped.
  - flush with start_valid in IDLE: flush wins, request not accepted.
- rd==0: computed and presented normally; the register file drops the write.
- start_valid while not IDLE: ignored. Requester must hold it until start_ready.

Optional Feature:
- Macro MULDIV_SIGNED_EN.
- Defined (full RV32M signed semantics):
  - Operands converted to magnitude at accept; sign correction applied combinationally on the DONE result; latency unchanged.
  - MULH: signed x signed. MULHSU: signed src1 x unsigned src2. DIV/REM: round toward zero, remainder takes the dividend's sign.
  - Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives 0x80000000; REM gives 0.
- Undefined: MULH/MULHSU behave as MULHU, DIV as DIVU, REM as REMU. Unsigned ops are identical in both builds.

Test Plan:
- MUL src1=7, src2=6, rd=3 -> result_valid at edge 33 after accept, result=42, result_rd=3.
- MULHU src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0xFFFFFFFE. MUL with same operands -> 0x00000001.
- DIVU 100/7 -> 14; REMU 100/7 -> 2. DIVU 5/0 -> 0xFFFFFFFF after 1 edge; REMU 5/0 -> 5.
- Hold result_ready=0 for 10 cycles in DONE -> result/result_valid stable, start_ready=0, new start_valid ignored. Then result_ready=1 -> IDLE next edge.
- flush at BUSY cycle 10 -> IDLE next edge, result_valid never asserted. flush+start_valid in IDLE -> not accepted. reset_n low mid-BUSY -> all outputs at reset values immediately.
- With MULDIV_SIGNED_EN:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - MULH -1*-1 -> 0.
- Without MULDIV_SIGNED_EN: MULH -1*-1 -> 0xFFFFFFFE.
